// File: rtl/lc3b_types.sv
// Shared tag-width and counter-width constants for the LC-3b tag-matching
// comparators (branch target buffer and cache ways).
package lc3b_types;

    // Tag width used by the branch target buffer ways.
    localparam int unsigned BTB_TAG_W     = 10;

    // Default operand width for a generic comparator instance.
    localparam int unsigned DEFAULT_TAG_W = 16;

    // Default width of the saturating match counter.
    localparam int unsigned DEFAULT_CNT_W = 8;

endpackage : lc3b_types

// File: rtl/compare.sv
// Tag comparator: combinational equal / less-than / greater-than on two
// unsigned operands, plus a registered copy of the equality result and a
// saturating count of cycles in which the operands matched.
module compare
    import lc3b_types::*;
#(
    parameter int unsigned width = DEFAULT_TAG_W,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic             out,
    output logic             lt,
    output logic             gt,
    output logic             out_q,
    output logic [CNT_W-1:0] match_count
);

    // Counter value at which counting stops.
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             eq_s;
    logic             lt_s;
    logic             gt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             out_q_r;
    logic [CNT_W-1:0] match_count_r;

    // Equality is the AND-reduction of the per-bit XNOR so every bit,
    // including the MSB, participates; works unchanged for width == 1.
    assign eq_s = &(a ~^ b);

    // Both operands are declared unsigned, so these relationals are
    // plain unsigned magnitude compares with no sign extension.
    assign lt_s = (a < b);
    assign gt_s = (a > b);

    // Combinational results go straight out so a hit is usable this cycle;
    // they ignore clk and rst and stay valid during reset.
    assign out = eq_s;
    assign lt  = lt_s;
    assign gt  = gt_s;

    // Next match count: step by one on a match, but hold once at all-ones.
    always_comb begin
        cnt_nxt_s = match_count_r;
        if (eq_s && (match_count_r != CNT_MAX)) begin
            cnt_nxt_s = match_count_r + CNT_W'(1'b1);
        end else begin
            cnt_nxt_s = match_count_r;
        end
    end

    // Registered copy of the equality result, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q_r <= 1'b0;
        end else begin
            out_q_r <= eq_s;
        end
    end

    // Saturating match counter, cleared by reset regardless of the compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_count_r <= '0;
        end else begin
            match_count_r <= cnt_nxt_s;
        end
    end

    assign out_q       = out_q_r;
    assign match_count = match_count_r;

endmodule : compare

// File: tb/tb_compare.sv
// Self-checking bench for compare: a 10-bit instance with an 8-bit counter,
// a 10-bit instance with a 2-bit counter, and a 1-bit instance, all checked
// against a plain arithmetic reference model.
module tb_compare;

    logic       clk;
    logic       rst;
    logic [9:0] a10;
    logic [9:0] b10;
    logic       a1;
    logic       b1;

    logic       out10, lt10, gt10, oq10;
    logic [7:0] mc10;
    logic       out10s, lt10s, gt10s, oq10s;
    logic [1:0] mc10s;
    logic       out1, lt1, gt1, oq1;
    logic [3:0] mc1;

    int tests_run;
    int tests_failed;

    // reference model state
    int m_q10;
    int m_c8;
    int m_c2;
    int m_q1;
    int m_c1;

    compare #(.width(10), .CNT_W(8)) u_c10 (
        .clk(clk), .rst(rst), .a(a10), .b(b10),
        .out(out10), .lt(lt10), .gt(gt10), .out_q(oq10), .match_count(mc10)
    );

    compare #(.width(10), .CNT_W(2)) u_c10s (
        .clk(clk), .rst(rst), .a(a10), .b(b10),
        .out(out10s), .lt(lt10s), .gt(gt10s), .out_q(oq10s), .match_count(mc10s)
    );

    compare #(.width(1), .CNT_W(4)) u_c1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1),
        .out(out1), .lt(lt1), .gt(gt1), .out_q(oq1), .match_count(mc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check combinational outputs,
    // advance the model at the edge, then check registered outputs.
    task automatic cycle(input logic r, input logic [9:0] na, input logic [9:0] nb,
                         input logic n1a, input logic n1b);
        int ia, ib, ja, jb;
        @(negedge clk);
        rst = r; a10 = na; b10 = nb; a1 = n1a; b1 = n1b;
        ia = int'(na); ib = int'(nb); ja = int'(n1a); jb = int'(n1b);
        #1;
        chk("out10",  {31'd0, out10},  (ia == ib) ? 32'd1 : 32'd0);
        chk("lt10",   {31'd0, lt10},   (ia <  ib) ? 32'd1 : 32'd0);
        chk("gt10",   {31'd0, gt10},   (ia >  ib) ? 32'd1 : 32'd0);
        chk("out10s", {31'd0, out10s}, (ia == ib) ? 32'd1 : 32'd0);
        chk("lt10s",  {31'd0, lt10s},  (ia <  ib) ? 32'd1 : 32'd0);
        chk("gt10s",  {31'd0, gt10s},  (ia >  ib) ? 32'd1 : 32'd0);
        chk("out1",   {31'd0, out1},   (ja == jb) ? 32'd1 : 32'd0);
        chk("lt1",    {31'd0, lt1},    (ja <  jb) ? 32'd1 : 32'd0);
        chk("gt1",    {31'd0, gt1},    (ja >  jb) ? 32'd1 : 32'd0);
        @(posedge clk);
        if (r) begin
            m_q10 = 0; m_c8 = 0; m_c2 = 0; m_q1 = 0; m_c1 = 0;
        end else begin
            m_q10 = (ia == ib) ? 1 : 0;
            if (ia == ib) begin
                if (m_c8 < 255) m_c8 = m_c8 + 1;
                if (m_c2 < 3)   m_c2 = m_c2 + 1;
            end
            m_q1 = (ja == jb) ? 1 : 0;
            if ((ja == jb) && (m_c1 < 15)) m_c1 = m_c1 + 1;
        end
        #1;
        chk("out_q10",  {31'd0, oq10},  32'(m_q10));
        chk("count10",  {24'd0, mc10},  32'(m_c8));
        chk("out_q10s", {31'd0, oq10s}, 32'(m_q10));
        chk("count10s", {30'd0, mc10s}, 32'(m_c2));
        chk("out_q1",   {31'd0, oq1},   32'(m_q1));
        chk("count1",   {28'd0, mc1},   32'(m_c1));
    endtask

    initial begin
        logic [9:0] ra;
        logic [9:0] rb;
        logic       rr;
        tests_run = 0; tests_failed = 0;
        m_q10 = 0; m_c8 = 0; m_c2 = 0; m_q1 = 0; m_c1 = 0;
        rst = 1'b1; a10 = 10'h000; b10 = 10'h000; a1 = 1'b0; b1 = 1'b0;

        // reset with equal operands: out high combinationally, out_q held low
        cycle(1'b1, 10'h155, 10'h155, 1'b1, 1'b1);
        cycle(1'b1, 10'h155, 10'h155, 1'b1, 1'b1);
        chk("rst_out",   {31'd0, out10}, 32'd1);
        chk("rst_out_q", {31'd0, oq10},  32'd0);

        // release reset: five matching edges
        for (int i = 0; i < 5; i++) cycle(1'b0, 10'h155, 10'h155, 1'b0, 1'b0);
        chk("post_rst_out_q", {31'd0, oq10}, 32'd1);
        chk("count_after5",   {24'd0, mc10}, 32'd5);

        // one reset edge clears both registered outputs
        cycle(1'b1, 10'h155, 10'h155, 1'b0, 1'b0);
        chk("count_cleared", {24'd0, mc10}, 32'd0);
        chk("out_q_cleared", {31'd0, oq10}, 32'd0);

        // six matching edges saturate the 2-bit counter at 3
        for (int i = 0; i < 6; i++) cycle(1'b0, 10'h2AA, 10'h2AA, 1'b1, 1'b0);
        chk("sat2",   {30'd0, mc10s}, 32'd3);
        chk("count6", {24'd0, mc10},  32'd6);

        // magnitude corners
        cycle(1'b0, 10'h155, 10'h154, 1'b1, 1'b0);
        chk("gt_155_154", {31'd0, gt10}, 32'd1);
        cycle(1'b0, 10'h000, 10'h3FF, 1'b0, 1'b1);
        chk("lt_000_3ff", {31'd0, lt10}, 32'd1);
        cycle(1'b0, 10'h200, 10'h000, 1'b0, 1'b0);
        chk("msb_gt", {31'd0, gt10}, 32'd1);
        chk("msb_eq", {31'd0, out10}, 32'd0);
        cycle(1'b0, 10'h000, 10'h200, 1'b1, 1'b1);
        chk("msb_lt", {31'd0, lt10}, 32'd1);

        // randomized traffic with occasional resets and frequent matches
        for (int i = 0; i < 400; i++) begin
            ra = 10'($urandom_range(0, 1023));
            case ($urandom_range(0, 3))
                0, 1:    rb = ra;
                2:       rb = ra ^ (10'h001 << $urandom_range(0, 9));
                default: rb = 10'($urandom_range(0, 1023));
            endcase
            rr = ($urandom_range(0, 39) == 0);
            cycle(rr, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_compare
